// File: rtl/load_subword_unit_if.sv
// rtl/load_subword_unit_if.sv - request, result and data-bus signals of the load sub-word unit
//
// Purpose: bundles the MEM-stage load request, the returned register value and
//   the Avalon-style read bus into one interface.
// Modports:
//   slave  - used by load_subword_unit (consumes requests and read data,
//            drives ready/stall/bus strobes/result)
//   master - used by the surrounding pipeline and memory (drives requests and
//            read data, observes everything else)
// Signals:
//   req_valid/req_opcode/req_addr/req_rt  load request, opcode, byte address, rt merge source
//   req_ready, stall                      acceptance window and pipeline freeze
//   mem_address/mem_read/mem_byteenable   word-aligned read strobe and lanes
//   mem_waitrequest/mem_readdata          bus back-pressure and returned word
//   result_valid/result_data              final rt write value
//   misaligned                            one-cycle address-error pulse

interface load_subword_unit_if;
  logic        req_valid;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_rt;
  logic        req_ready;
  logic        stall;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        result_valid;
  logic [31:0] result_data;
  logic        misaligned;

  modport slave (
    input  req_valid, req_opcode, req_addr, req_rt,
    input  mem_waitrequest, mem_readdata,
    output req_ready, stall,
    output mem_address, mem_read, mem_byteenable,
    output result_valid, result_data, misaligned
  );

  modport master (
    output req_valid, req_opcode, req_addr, req_rt,
    output mem_waitrequest, mem_readdata,
    input  req_ready, stall,
    input  mem_address, mem_read, mem_byteenable,
    input  result_valid, result_data, misaligned
  );
endinterface

// File: rtl/load_subword_unit.sv
// rtl/load_subword_unit.sv - MIPS I LB/LBU/LH/LHU/LW/LWL/LWR executed as one aligned word read
//
// Purpose: accepts a load from the MEM stage, issues a single word-aligned read
//   on the data bus, then extracts, sign/zero-extends or merges (LWL/LWR) the
//   returned word into the rt write value. Holds stall high while busy.
// Ports:
//   clk_i         system clock, all state on posedge
//   reset_i       synchronous, active-high reset
//   clk_enable_i  gates request acceptance and the DONE->IDLE step; the bus
//                 handshake in READ ignores it
//   bus_if        load_subword_unit_if.slave (request, result and bus signals)

module load_subword_unit (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clk_enable_i,
  load_subword_unit_if.slave   bus_if
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rt_q, rt_d;
  logic        ready_q, ready_d;
  logic        stall_q, stall_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [3:0]  be_q, be_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misal_q, misal_d;

  // Request decode
  logic        req_legal;
  logic        req_aligned;
  logic [3:0]  req_be;
  logic [1:0]  req_lane;

  assign req_lane = bus_if.req_addr[1:0];

  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b1;
    req_be      = 4'b1111;
    case (bus_if.req_opcode)
      OP_LB, OP_LBU: begin
        req_legal = 1'b1;
        req_be    = 4'b0001 << req_lane;
      end
      OP_LH, OP_LHU: begin
        req_legal   = 1'b1;
        req_aligned = (req_lane[0] == 1'b0);
        req_be      = req_lane[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        req_legal   = 1'b1;
        req_aligned = (req_lane == 2'b00);
      end
      OP_LWL, OP_LWR: begin
        // Unaligned word loads are legal by construction; the merge covers any lane.
        req_legal = 1'b1;
      end
      default: begin
        req_legal = 1'b0;
      end
    endcase
  end

  // Builds the rt write value from the returned word and the latched request.
  function automatic logic [31:0] extract(input logic [5:0]  op,
                                          input logic [1:0]  a,
                                          input logic [31:0] rt,
                                          input logic [31:0] m);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = m >> {a, 3'b000};
    b       = shifted[7:0];
    h       = a[1] ? m[31:16] : m[15:0];
    r       = m;
    case (op)
      OP_LB:  r = {{24{b[7]}}, b};
      OP_LBU: r = {24'b0, b};
      OP_LH:  r = {{16{h[15]}}, h};
      OP_LHU: r = {16'b0, h};
      OP_LW:  r = m;
      OP_LWL: begin
        // Low memory bytes land in the high end of rt.
        case (a)
          2'd0:    r = {m[7:0],  rt[23:0]};
          2'd1:    r = {m[15:0], rt[15:0]};
          2'd2:    r = {m[23:0], rt[7:0]};
          default: r = m;
        endcase
      end
      OP_LWR: begin
        // High memory bytes land in the low end of rt.
        case (a)
          2'd0:    r = m;
          2'd1:    r = {rt[31:24], m[31:8]};
          2'd2:    r = {rt[31:16], m[31:16]};
          default: r = {rt[31:8],  m[31:24]};
        endcase
      end
      default: r = m;
    endcase
    return r;
  endfunction

  // Next-state logic; every output is a register so nothing combinational
  // reaches the bus or the pipeline.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    lane_d   = lane_q;
    rt_d     = rt_q;
    ready_d  = ready_q;
    stall_d  = stall_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    be_d     = be_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    misal_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus_if.req_valid && clk_enable_i && req_legal) begin
          if (!req_aligned) begin
            misal_d = 1'b1;
          end else begin
            state_d = ST_READ;
            op_d    = bus_if.req_opcode;
            lane_d  = req_lane;
            rt_d    = bus_if.req_rt;
            addr_d  = {bus_if.req_addr[31:2], 2'b00};
            be_d    = req_be;
            rd_d    = 1'b1;
            ready_d = 1'b0;
            stall_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (!bus_if.mem_waitrequest) begin
          state_d  = ST_DONE;
          rd_d     = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = extract(op_q, lane_q, rt_q, bus_if.mem_readdata);
        end
      end
      ST_DONE: begin
        // ready only rises after this edge, so no accept can coincide with it.
        if (clk_enable_i) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
          stall_d  = 1'b0;
          ready_d  = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rd_d     = 1'b0;
        rvalid_d = 1'b0;
        stall_d  = 1'b0;
        ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      op_q     <= 6'b0;
      lane_q   <= 2'b0;
      rt_q     <= 32'b0;
      ready_q  <= 1'b1;
      stall_q  <= 1'b0;
      addr_q   <= 32'b0;
      rd_q     <= 1'b0;
      be_q     <= 4'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'b0;
      misal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      lane_q   <= lane_d;
      rt_q     <= rt_d;
      ready_q  <= ready_d;
      stall_q  <= stall_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      be_q     <= be_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      misal_q  <= misal_d;
    end
  end

  assign bus_if.req_ready      = ready_q;
  assign bus_if.stall          = stall_q;
  assign bus_if.mem_address    = addr_q;
  assign bus_if.mem_read       = rd_q;
  assign bus_if.mem_byteenable = be_q;
  assign bus_if.result_valid   = rvalid_q;
  assign bus_if.result_data    = rdata_q;
  assign bus_if.misaligned     = misal_q;

endmodule

// File: tb/tb_load_subword_unit.sv
// tb/tb_load_subword_unit.sv - directed self-checking bench for load_subword_unit

module tb_load_subword_unit;

  logic clk;
  logic reset;
  logic clk_enable;
  int   n_vec;
  int   n_err;

  load_subword_unit_if bus_if ();

  load_subword_unit dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .clk_enable_i (clk_enable),
    .bus_if       (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt);
    bus_if.req_valid  = 1'b1;
    bus_if.req_opcode = op;
    bus_if.req_addr   = addr;
    bus_if.req_rt     = rt;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    clk_enable = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_opcode = 6'b0;
    bus_if.req_addr = 32'h0;
    bus_if.req_rt = 32'h0;
    bus_if.mem_waitrequest = 1'b0;
    bus_if.mem_readdata = 32'h0;

    // Reset state
    step();
    step();
    chk("rst_ready",  32'(bus_if.req_ready), 32'd1);
    chk("rst_stall",  32'(bus_if.stall), 32'd0);
    chk("rst_read",   32'(bus_if.mem_read), 32'd0);
    chk("rst_valid",  32'(bus_if.result_valid), 32'd0);
    chk("rst_misal",  32'(bus_if.misaligned), 32'd0);
    chk("rst_addr",   bus_if.mem_address, 32'h0);
    chk("rst_be",     32'(bus_if.mem_byteenable), 32'h0);
    chk("rst_data",   bus_if.result_data, 32'h0);
    reset = 1'b0;

    // LB 0x1003, readdata 0x80FF1234, no wait
    request(6'b100000, 32'h0000_1003, 32'h0);
    bus_if.mem_readdata = 32'h80FF_1234;
    step();
    bus_if.req_valid = 1'b0;
    chk("lb_c1_read",  32'(bus_if.mem_read), 32'd1);
    chk("lb_c1_addr",  bus_if.mem_address, 32'h0000_1000);
    chk("lb_c1_be",    32'(bus_if.mem_byteenable), 32'b1000);
    chk("lb_c1_stall", 32'(bus_if.stall), 32'd1);
    chk("lb_c1_ready", 32'(bus_if.req_ready), 32'd0);
    step();
    chk("lb_c2_valid", 32'(bus_if.result_valid), 32'd1);
    chk("lb_c2_data",  bus_if.result_data, 32'hFFFF_FF80);
    chk("lb_c2_read",  32'(bus_if.mem_read), 32'd0);
    step();
    chk("lb_idle_ready", 32'(bus_if.req_ready), 32'd1);
    chk("lb_idle_valid", 32'(bus_if.result_valid), 32'd0);
    chk("lb_idle_stall", 32'(bus_if.stall), 32'd0);

    // LHU 0x2002 with 3 wait cycles; junk data while waiting must be ignored
    request(6'b100101, 32'h0000_2002, 32'h0);
    bus_if.mem_waitrequest = 1'b1;
    bus_if.mem_readdata = 32'hDEAD_DEAD;
    step();
    bus_if.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus_if.mem_waitrequest = 1'b0;
        bus_if.mem_readdata = 32'hBEEF_0000;
      end
      chk($sformatf("lhu_read_c%0d", i + 1), 32'(bus_if.mem_read), 32'd1);
      chk($sformatf("lhu_be_c%0d", i + 1), 32'(bus_if.mem_byteenable), 32'b1100);
      chk($sformatf("lhu_valid_c%0d", i + 1), 32'(bus_if.result_valid), 32'd0);
      step();
    end
    chk("lhu_c5_valid", 32'(bus_if.result_valid), 32'd1);
    chk("lhu_c5_data",  bus_if.result_data, 32'h0000_BEEF);
    chk("lhu_c5_read",  32'(bus_if.mem_read), 32'd0);
    step();

    // LWL 0x1001 with rt changed after accept (must use latched rt)
    request(6'b100010, 32'h0000_1001, 32'hAABB_CCDD);
    bus_if.mem_readdata = 32'h1122_3344;
    step();
    bus_if.req_valid = 1'b0;
    bus_if.req_rt = 32'h0;
    bus_if.req_opcode = 6'b100000;
    chk("lwl_be", 32'(bus_if.mem_byteenable), 32'b1111);
    step();
    chk("lwl_data", bus_if.result_data, 32'h3344_CCDD);
    step();

    // LWR 0x1001
    request(6'b100110, 32'h0000_1001, 32'hAABB_CCDD);
    step();
    bus_if.req_valid = 1'b0;
    step();
    chk("lwr_data", bus_if.result_data, 32'hAA11_2233);
    step();

    // LWR lane 3 and LWL lane 0
    request(6'b100110, 32'h0000_1003, 32'hAABB_CCDD);
    step();
    bus_if.req_valid = 1'b0;
    step();
    chk("lwr3_data", bus_if.result_data, 32'hAABB_CC11);
    step();
    request(6'b100010, 32'h0000_1000, 32'hAABB_CCDD);
    step();
    bus_if.req_valid = 1'b0;
    step();
    chk("lwl0_data", bus_if.result_data, 32'h44BB_CCDD);
    step();

    // LH lane 2 negative, LBU lane 3, LW
    request(6'b100001, 32'h0000_2002, 32'h0);
    bus_if.mem_readdata = 32'h8001_0000;
    step();
    bus_if.req_valid = 1'b0;
    chk("lh_be", 32'(bus_if.mem_byteenable), 32'b1100);
    step();
    chk("lh_data", bus_if.result_data, 32'hFFFF_8001);
    step();
    request(6'b100100, 32'h0000_1003, 32'h0);
    bus_if.mem_readdata = 32'h80FF_1234;
    step();
    bus_if.req_valid = 1'b0;
    step();
    chk("lbu_data", bus_if.result_data, 32'h0000_0080);
    step();
    request(6'b100011, 32'h0000_3000, 32'h0);
    bus_if.mem_readdata = 32'h1234_5678;
    step();
    bus_if.req_valid = 1'b0;
    chk("lw_addr", bus_if.mem_address, 32'h0000_3000);
    step();
    chk("lw_data", bus_if.result_data, 32'h1234_5678);
    step();

    // Misaligned LH 0x2001
    request(6'b100001, 32'h0000_2001, 32'h0);
    step();
    bus_if.req_valid = 1'b0;
    chk("mis_lh_pulse", 32'(bus_if.misaligned), 32'd1);
    chk("mis_lh_read",  32'(bus_if.mem_read), 32'd0);
    chk("mis_lh_ready", 32'(bus_if.req_ready), 32'd1);
    step();
    chk("mis_lh_clear", 32'(bus_if.misaligned), 32'd0);
    chk("mis_lh_read2", 32'(bus_if.mem_read), 32'd0);

    // Misaligned LW 0x1002
    request(6'b100011, 32'h0000_1002, 32'h0);
    step();
    bus_if.req_valid = 1'b0;
    chk("mis_lw_pulse", 32'(bus_if.misaligned), 32'd1);
    chk("mis_lw_read",  32'(bus_if.mem_read), 32'd0);
    step();

    // Illegal opcode and clk_enable low in IDLE: nothing happens
    request(6'b001000, 32'h0000_1000, 32'h0);
    step();
    chk("ill_ready", 32'(bus_if.req_ready), 32'd1);
    chk("ill_read",  32'(bus_if.mem_read), 32'd0);
    chk("ill_misal", 32'(bus_if.misaligned), 32'd0);
    request(6'b100011, 32'h0000_1000, 32'h0);
    clk_enable = 1'b0;
    step();
    chk("ce0_read", 32'(bus_if.mem_read), 32'd0);
    bus_if.req_valid = 1'b0;
    clk_enable = 1'b1;

    // Reset during READ abandons the transaction
    request(6'b100011, 32'h0000_1000, 32'h0);
    bus_if.mem_waitrequest = 1'b1;
    step();
    bus_if.req_valid = 1'b0;
    chk("rr_read_before", 32'(bus_if.mem_read), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_if.mem_waitrequest = 1'b0;
    chk("rr_read",  32'(bus_if.mem_read), 32'd0);
    chk("rr_ready", 32'(bus_if.req_ready), 32'd1);
    chk("rr_valid", 32'(bus_if.result_valid), 32'd0);
    step();

    // DONE held while clk_enable=0; illegal opcode ignored
    request(6'b100000, 32'h0000_1000, 32'h0);
    bus_if.mem_readdata = 32'h0000_007F;
    step();
    bus_if.req_valid = 1'b0;
    step();
    clk_enable = 1'b0;
    request(6'b001000, 32'h0000_1000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_valid_%0d", i), 32'(bus_if.result_valid), 32'd1);
      chk($sformatf("hold_data_%0d", i), bus_if.result_data, 32'h0000_007F);
      chk($sformatf("hold_stall_%0d", i), 32'(bus_if.stall), 32'd1);
    end

    // No accept on the DONE->IDLE edge, accept on the next one
    request(6'b100011, 32'h0000_4000, 32'h0);
    bus_if.mem_readdata = 32'hCAFE_F00D;
    clk_enable = 1'b1;
    step();
    chk("d2i_ready", 32'(bus_if.req_ready), 32'd1);
    chk("d2i_read",  32'(bus_if.mem_read), 32'd0);
    step();
    bus_if.req_valid = 1'b0;
    chk("next_read", 32'(bus_if.mem_read), 32'd1);
    chk("next_addr", bus_if.mem_address, 32'h0000_4000);
    step();
    chk("next_data", bus_if.result_data, 32'hCAFE_F00D);
    step();
    chk("final_ready", 32'(bus_if.req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
